mem_stage: RTL and testbench

- MEM stage of the 5-stage MIPS pipeline; consumes the EX/MEM outputs of Execute.
- Performs loads and stores through a small direct-mapped, write-through, no-write-allocate data cache backed by a word-wide main-memory handshake.
- Resolves branches (PCSrc) and drives the MEM/WB pipeline register.
- Stalls the pipeline on a load miss or any store until memory acknowledges.

---
 rtl/mem_pkg.sv | 20 ++
 rtl/dcache_array.sv | 47 ++++
 rtl/mem_stage.sv | 159 +++++++++++++++
 tb/tb_mem_stage.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage and its data cache.
//   state_e     : MEM-stage access FSM states
//   CACHE_LINES : default number of one-word cache lines
//   ADDR_W      : default byte-address width
//   INDEX_W     : cache index width for the default geometry
//   TAG_W       : cache tag width for the default geometry
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_MISS = 2'd1,
      WR_WAIT = 2'd2
   } state_e;

   localparam int CACHE_LINES = 16;
   localparam int ADDR_W      = 32;
   localparam int INDEX_W     = $clog2(CACHE_LINES);
   localparam int TAG_W       = ADDR_W - 2 - INDEX_W;

endpackage

// File: rtl/dcache_array.sv
// Direct-mapped data cache storage, one 32-bit word per line.
//   clk, rstn : clock, async active-low reset (clears valid bits only)
//   idx_i     : line index for both lookup and write
//   tag_i     : tag compared on lookup and stored on write
//   hit_o     : selected line is valid and its tag matches
//   rdata_o   : data word of the selected line
//   we_i      : write (fill or store update) at the next rising edge
//   wdata_i   : word written when we_i is set
module dcache_array #(
   parameter int LINES = 16,
   parameter int IW    = 4,
   parameter int TW    = 26
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic [IW-1:0] idx_i,
   input  logic [TW-1:0] tag_i,
   output logic          hit_o,
   output logic [31:0]   rdata_o,
   input  logic          we_i,
   input  logic [31:0]   wdata_i
);

   logic [LINES-1:0] valid_q;
   logic [TW-1:0]    tag_q  [LINES];
   logic [31:0]      data_q [LINES];

   assign hit_o   = valid_q[idx_i] & (tag_q[idx_i] == tag_i);
   assign rdata_o = data_q[idx_i];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         valid_q <= '0;
      end else if (we_i) begin
         valid_q[idx_i] <= 1'b1;
      end
   end

   // Tag/data need no reset: a line is only ever read through its valid bit.
   always_ff @(posedge clk) begin
      if (we_i) begin
         tag_q[idx_i]  <= tag_i;
         data_q[idx_i] <= wdata_i;
      end
   end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline.
// Loads/stores go through a direct-mapped, write-through, no-write-allocate
// cache backed by a word-wide req/ack memory port; resolves branches and
// drives the MEM/WB register.
//   clk, rstn              : clock, async active-low reset
//   iSig_*                 : EX/MEM control (MemRead, MemWrite, Branch, MemtoReg, RegWrite)
//   iadder_branch_result   : branch target       -> obranch_target
//   iALU_zero              : ALU zero flag        -> oPCSrc
//   iALU_result            : effective address / ALU result
//   iregfile_read_2        : store data
//   ireg_write_reg         : destination register
//   oPCSrc, obranch_target : branch resolution
//   ostall, ocachehit      : pipeline freeze, cache hit of the current access
//   oread_data, oALU_result, oreg_write_reg, oSig_RegWrite, oSig_MemtoReg : MEM/WB
//   omem_req/we/addr/wdata, imem_rdata, imem_ack : main-memory handshake
module mem_stage
   import mem_pkg::*;
#(
   parameter int LINES = CACHE_LINES,
   parameter int AW    = ADDR_W
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        iSig_MemRead,
   input  logic        iSig_MemWrite,
   input  logic        iSig_Branch,
   input  logic        iSig_MemtoReg,
   input  logic        iSig_RegWrite,
   input  logic [31:0] iadder_branch_result,
   input  logic        iALU_zero,
   input  logic [31:0] iALU_result,
   input  logic [31:0] iregfile_read_2,
   input  logic [4:0]  ireg_write_reg,
   output logic        oPCSrc,
   output logic [31:0] obranch_target,
   output logic        ostall,
   output logic        ocachehit,
   output logic [31:0] oread_data,
   output logic [31:0] oALU_result,
   output logic [4:0]  oreg_write_reg,
   output logic        oSig_RegWrite,
   output logic        oSig_MemtoReg,
   output logic        omem_req,
   output logic        omem_we,
   output logic [31:0] omem_addr,
   output logic [31:0] omem_wdata,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ack
);

   localparam int IW = $clog2(LINES);
   localparam int TW = AW - 2 - IW;

   state_e        state_q, state_d;
   logic [IW-1:0] idx;
   logic [TW-1:0] tag;
   logic          hit, is_rd, is_wr, in_idle;
   logic          rd_txn, wr_txn, req, ack, done_rd;
   logic          cache_we;
   logic [31:0]   cache_rdata, cache_wdata;

   logic          rw_d, mtr_d;
   logic [31:0]   rdata_d, alu_d;
   logic [4:0]    wreg_d;

   assign idx = iALU_result[IW+1:2];
   assign tag = iALU_result[AW-1:IW+2];

   dcache_array #(.LINES(LINES), .IW(IW), .TW(TW)) u_cache (
      .clk     (clk),
      .rstn    (rstn),
      .idx_i   (idx),
      .tag_i   (tag),
      .hit_o   (hit),
      .rdata_o (cache_rdata),
      .we_i    (cache_we),
      .wdata_i (cache_wdata)
   );

   // MemRead together with MemWrite is handled purely as a store.
   assign is_wr   = iSig_MemWrite;
   assign is_rd   = iSig_MemRead & ~iSig_MemWrite;
   assign in_idle = (state_q == IDLE);

   // Outstanding transaction type: decided from inputs in IDLE so the request
   // goes out in the miss cycle itself, from the state afterwards.
   assign rd_txn = in_idle ? (is_rd & ~hit) : (state_q == RD_MISS);
   assign wr_txn = in_idle ? is_wr          : (state_q == WR_WAIT);

   // Gating with rstn drops the request the instant reset asserts, even if
   // upstream still presents a load.
   assign req     = rstn & (rd_txn | wr_txn);
   assign ack     = req & imem_ack;
   assign done_rd = ack & rd_txn;

   assign ostall     = req & ~imem_ack;
   assign ocachehit  = in_idle & (iSig_MemRead | iSig_MemWrite) & hit;
   assign omem_req   = req;
   assign omem_we    = req & wr_txn;
   assign omem_addr  = req ? {iALU_result[31:2], 2'b00} : 32'd0;
   assign omem_wdata = omem_we ? iregfile_read_2 : 32'd0;

   // Fill on load completion; store updates only a line it already hits.
   assign cache_we    = done_rd | (ack & wr_txn & hit);
   assign cache_wdata = done_rd ? imem_rdata : iregfile_read_2;

   assign oPCSrc         = iSig_Branch & iALU_zero;
   assign obranch_target = iadder_branch_result;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req & ~imem_ack) state_d = is_wr ? WR_WAIT : RD_MISS;
         RD_MISS: if (imem_ack) state_d = IDLE;
         WR_WAIT: if (imem_ack) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // MEM/WB next value: a bubble while stalled, otherwise the EX/MEM entry
   // with load data from memory (miss) or the cache (hit).
   always_comb begin
      rw_d    = 1'b0;
      mtr_d   = 1'b0;
      rdata_d = 32'd0;
      alu_d   = 32'd0;
      wreg_d  = 5'd0;
      if (!ostall) begin
         rw_d   = iSig_RegWrite;
         mtr_d  = iSig_MemtoReg;
         alu_d  = iALU_result;
         wreg_d = ireg_write_reg;
         if (done_rd)                    rdata_d = imem_rdata;
         else if (in_idle & is_rd & hit) rdata_d = cache_rdata;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         oSig_RegWrite  <= 1'b0;
         oSig_MemtoReg  <= 1'b0;
         oread_data     <= 32'd0;
         oALU_result    <= 32'd0;
         oreg_write_reg <= 5'd0;
      end else begin
         oSig_RegWrite  <= rw_d;
         oSig_MemtoReg  <= mtr_d;
         oread_data     <= rdata_d;
         oALU_result    <= alu_d;
         oreg_write_reg <= wreg_d;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: each instruction pushes its expected MEM/WB
// entry when driven and the entry is popped and compared when it retires.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rstn;
   logic        iSig_MemRead, iSig_MemWrite, iSig_Branch, iSig_MemtoReg, iSig_RegWrite;
   logic [31:0] iadder_branch_result, iALU_result, iregfile_read_2, imem_rdata;
   logic        iALU_zero, imem_ack;
   logic [4:0]  ireg_write_reg;
   logic        oPCSrc, ostall, ocachehit, oSig_RegWrite, oSig_MemtoReg;
   logic        omem_req, omem_we;
   logic [31:0] obranch_target, oread_data, oALU_result, omem_addr, omem_wdata;
   logic [4:0]  oreg_write_reg;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic        rw;
      logic        mtr;
      logic [31:0] rd;
      logic [31:0] alu;
      logic [4:0]  wreg;
   } wb_t;

   wb_t sb[$];

   always #5 clk = ~clk;

   mem_stage dut (
      .clk                  (clk),
      .rstn                 (rstn),
      .iSig_MemRead         (iSig_MemRead),
      .iSig_MemWrite        (iSig_MemWrite),
      .iSig_Branch          (iSig_Branch),
      .iSig_MemtoReg        (iSig_MemtoReg),
      .iSig_RegWrite        (iSig_RegWrite),
      .iadder_branch_result (iadder_branch_result),
      .iALU_zero            (iALU_zero),
      .iALU_result          (iALU_result),
      .iregfile_read_2      (iregfile_read_2),
      .ireg_write_reg       (ireg_write_reg),
      .oPCSrc               (oPCSrc),
      .obranch_target       (obranch_target),
      .ostall               (ostall),
      .ocachehit            (ocachehit),
      .oread_data           (oread_data),
      .oALU_result          (oALU_result),
      .oreg_write_reg       (oreg_write_reg),
      .oSig_RegWrite        (oSig_RegWrite),
      .oSig_MemtoReg        (oSig_MemtoReg),
      .omem_req             (omem_req),
      .omem_we              (omem_we),
      .omem_addr            (omem_addr),
      .omem_wdata           (omem_wdata),
      .imem_rdata           (imem_rdata),
      .imem_ack             (imem_ack)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      iSig_MemRead = 1'b0; iSig_MemWrite = 1'b0; iSig_Branch = 1'b0;
      iSig_MemtoReg = 1'b0; iSig_RegWrite = 1'b0; iALU_zero = 1'b0;
      iadder_branch_result = 32'd0; iALU_result = 32'd0; iregfile_read_2 = 32'd0;
      ireg_write_reg = 5'd0; imem_rdata = 32'd0; imem_ack = 1'b0;
   endtask

   task automatic check_wb(input string tag);
      wb_t e;
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s_sb: scoreboard empty, got rw=%0d", tag, oSig_RegWrite);
         return;
      end
      e = sb.pop_front();
      chk({tag, "_rw"},   32'(oSig_RegWrite),  32'(e.rw));
      chk({tag, "_mtr"},  32'(oSig_MemtoReg),  32'(e.mtr));
      chk({tag, "_rdat"}, oread_data,          e.rd);
      chk({tag, "_alu"},  oALU_result,         e.alu);
      chk({tag, "_wreg"}, 32'(oreg_write_reg), 32'(e.wreg));
   endtask

   // Waits out a memory transaction of lat stalled edges, acking in the last
   // cycle; lat=0 acks in the request cycle itself.
   task automatic mem_wait(input string tag, input int lat, input logic [31:0] data);
      for (int i = 1; i <= lat; i++) begin
         @(posedge clk); #1;
         chk({tag, "_bubble"}, 32'(oSig_RegWrite), 32'd0);
         chk({tag, "_reqhold"}, 32'(omem_req), 32'd1);
         @(negedge clk);
         if (i == lat) begin
            imem_ack = 1'b1; imem_rdata = data;
            #1 chk({tag, "_ackstall"}, 32'(ostall), 32'd0);
         end
      end
   endtask

   task automatic do_load(input string tag, input logic [31:0] addr, input bit exp_hit,
                          input int lat, input logic [31:0] data);
      wb_t e;
      @(negedge clk);
      iSig_MemRead = 1'b1; iALU_result = addr; ireg_write_reg = 5'd7;
      iSig_RegWrite = 1'b1; iSig_MemtoReg = 1'b1;
      imem_ack = (!exp_hit && lat == 0); imem_rdata = imem_ack ? data : 32'd0;
      #1;
      chk({tag, "_hit"},   32'(ocachehit), 32'(exp_hit));
      chk({tag, "_stall"}, 32'(ostall),    32'(!exp_hit && lat != 0));
      chk({tag, "_req"},   32'(omem_req),  32'(!exp_hit));
      if (!exp_hit) begin
         chk({tag, "_addr"}, omem_addr, {addr[31:2], 2'b00});
         chk({tag, "_we"},   32'(omem_we), 32'd0);
      end
      e = '{rw: 1'b1, mtr: 1'b1, rd: data, alu: addr, wreg: 5'd7};
      sb.push_back(e);
      if (!exp_hit) mem_wait(tag, lat, data);
      @(posedge clk); #1;
      check_wb(tag);
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic do_store(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                           input bit exp_hit, input bit also_rd, input int lat);
      wb_t e;
      @(negedge clk);
      iSig_MemWrite = 1'b1; iSig_MemRead = also_rd; iALU_result = addr;
      iregfile_read_2 = wd; ireg_write_reg = 5'd3;
      imem_ack = (lat == 0);
      #1;
      chk({tag, "_hit"},   32'(ocachehit), 32'(exp_hit));
      chk({tag, "_stall"}, 32'(ostall),    32'(lat != 0));
      chk({tag, "_req"},   32'(omem_req),  32'd1);
      chk({tag, "_we"},    32'(omem_we),   32'd1);
      chk({tag, "_wdata"}, omem_wdata,     wd);
      chk({tag, "_addr"},  omem_addr,      {addr[31:2], 2'b00});
      e = '{rw: 1'b0, mtr: 1'b0, rd: 32'd0, alu: addr, wreg: 5'd3};
      sb.push_back(e);
      mem_wait(tag, lat, 32'd0);
      @(posedge clk); #1;
      check_wb(tag);
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic do_alu(input string tag, input logic [31:0] val, input bit stray_ack);
      wb_t e;
      @(negedge clk);
      iSig_RegWrite = 1'b1; iALU_result = val; ireg_write_reg = 5'd9;
      imem_ack = stray_ack; imem_rdata = 32'hFFFF_FFFF;
      #1;
      chk({tag, "_stall"}, 32'(ostall),   32'd0);
      chk({tag, "_req"},   32'(omem_req), 32'd0);
      e = '{rw: 1'b1, mtr: 1'b0, rd: 32'd0, alu: val, wreg: 5'd9};
      sb.push_back(e);
      @(posedge clk); #1;
      check_wb(tag);
      @(negedge clk);
      idle_inputs();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      rstn = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_stall", 32'(ostall), 32'd0);
      chk("rst_hit",   32'(ocachehit), 32'd0);
      chk("rst_req",   32'(omem_req), 32'd0);
      chk("rst_rw",    32'(oSig_RegWrite), 32'd0);
      chk("rst_rdat",  oread_data, 32'd0);
      chk("rst_addr",  omem_addr, 32'd0);
      rstn = 1'b1;

      do_load("ld_miss40", 32'h40, 1'b0, 3, 32'hDEAD_BEEF);
      do_load("ld_hit40",  32'h40, 1'b1, 0, 32'hDEAD_BEEF);
      do_store("st_hit40", 32'h40, 32'h1234_5678, 1'b1, 1'b0, 2);
      do_load("ld_hit40b", 32'h40, 1'b1, 0, 32'h1234_5678);
      do_store("st_miss80", 32'h80, 32'hCAFE_F00D, 1'b0, 1'b0, 1);
      do_load("ld_miss80", 32'h81, 1'b0, 0, 32'hCAFE_F00D);
      do_load("ld_evict40", 32'h40, 1'b0, 2, 32'h1234_5678);
      do_load("ld_miss440", 32'h440, 1'b0, 1, 32'h0BAD_F00D);
      do_load("ld_conf40", 32'h40, 1'b0, 1, 32'h1234_5678);
      do_load("ld_hit40c", 32'h42, 1'b1, 0, 32'h1234_5678);
      do_alu("alu_ack", 32'h0000_0123, 1'b1);
      do_alu("alu_plain", 32'hFEDC_BA98, 1'b0);
      do_store("st_rdwr", 32'h104, 32'h55AA_55AA, 1'b0, 1'b1, 1);
      do_load("ld_104", 32'h104, 1'b0, 1, 32'h55AA_55AA);

      @(negedge clk);
      iSig_Branch = 1'b1; iALU_zero = 1'b1; iadder_branch_result = 32'h1000_0040;
      #1;
      chk("br_taken",  32'(oPCSrc), 32'd1);
      chk("br_target", obranch_target, 32'h1000_0040);
      iALU_zero = 1'b0;
      #1;
      chk("br_nottaken", 32'(oPCSrc), 32'd0);
      idle_inputs();

      // Reset asserted while a miss to 0x440 is outstanding.
      @(negedge clk);
      iSig_MemRead = 1'b1; iALU_result = 32'h440; ireg_write_reg = 5'd7;
      iSig_RegWrite = 1'b1; iSig_MemtoReg = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rmid_stall", 32'(ostall), 32'd1);
      rstn = 1'b0;
      #1;
      chk("rmid_req",   32'(omem_req), 32'd0);
      chk("rmid_stall0", 32'(ostall), 32'd0);
      chk("rmid_rw",    32'(oSig_RegWrite), 32'd0);
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      rstn = 1'b1;
      do_load("ld_after_rst", 32'h40, 1'b0, 1, 32'h1234_5678);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
